// File: rtl/var_shift.sv
// var_shift: registered variable-amount logical barrel shifter.
// One shared right-shift bank handles both directions; a left shift is done
// by bit-reversing the word on the way in and again on the way out.
module var_shift #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             dir,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [31:0]      shift,
    output logic [WIDTH-1:0] q
);

    localparam int LOG2 = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             ovf;
    logic [WIDTH-1:0] stg [0:LOG2];

    // Present the word to the right-shifter, reversed when shifting left
    always_comb begin
        src = '0;
        for (int i = 0; i < WIDTH; i++) begin
            src[i] = dir ? in[i] : in[WIDTH-1-i];
        end
    end

    assign stg[0] = src;

    // Stage k moves the word right by 2^k when shift bit k is set; zeros fill
    // from the top, so amounts between WIDTH and 2^LOG2-1 naturally clear it.
    generate
        for (genvar k = 0; k < LOG2; k++) begin : g_stage
            localparam int SH = 2 ** k;
            assign stg[k+1] = shift[k] ? (stg[k] >> SH) : stg[k];
        end
    endgenerate

    // Any shift bit at or above LOG2 means the amount is at least WIDTH
    assign ovf = |shift[31:LOG2];

    // Undo the input reversal for left shifts, and zero on overflow
    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = dir ? stg[LOG2][i] : stg[LOG2][WIDTH-1-i];
        end
        if (ovf) begin
            res = '0;
        end
    end

    // Load the new result only on enabled cycles
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = res;
        end
    end

    // Output register, cleared asynchronously by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_var_shift.sv
// Directed bench for var_shift: reset, both directions, hold, boundaries,
// back-to-back loads and a shift-amount sweep against a reference shift.
module tb_var_shift;

    logic        clk;
    logic        clr;
    logic        dir;
    logic        en;
    logic [31:0] in_v;
    logic [31:0] shift;
    logic [31:0] q;

    int n_tests = 0;
    int n_fail  = 0;

    var_shift #(.WIDTH(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .dir   (dir),
        .en    (en),
        .in    (in_v),
        .shift (shift),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Asserted from time 0
        #1;
        n_tests++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_initial q=%h exp=%h", q, 32'h0);
        end
        // Load something nonzero
        clr = 1'b0; en = 1'b1; dir = 1'b0; in_v = 32'h7105C1A6; shift = 32'd0;
        step();
        n_tests++;
        if (q !== 32'h7105C1A6) begin
            n_fail++;
            $display("FAIL reset_preload q=%h exp=%h", q, 32'h7105C1A6);
        end
        // Mid-cycle asynchronous clear, en still high
        #2;
        clr = 1'b1;
        #1;
        n_tests++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async q=%h exp=%h", q, 32'h0);
        end
        step();
        n_tests++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_en_ignored q=%h exp=%h", q, 32'h0);
        end
        // Release: first enabled edge loads
        clr = 1'b0;
        step();
        n_tests++;
        if (q !== 32'h7105C1A6) begin
            n_fail++;
            $display("FAIL reset_release q=%h exp=%h", q, 32'h7105C1A6);
        end
    endtask

    task automatic test_left();
        in_v = 32'h7105C1A6; dir = 1'b0; shift = 32'd12; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (q !== 32'h5C1A6000) begin
                n_fail++;
                $display("FAIL left_12 edge%0d q=%h exp=%h", i, q, 32'h5C1A6000);
            end
        end
    endtask

    task automatic test_right();
        in_v = 32'h7105C1A6; dir = 1'b1; shift = 32'd5; en = 1'b1;
        step();
        n_tests++;
        if (q !== 32'h03882E0D) begin
            n_fail++;
            $display("FAIL right_5 q=%h exp=%h", q, 32'h03882E0D);
        end
    endtask

    task automatic test_hold();
        in_v = 32'h7105C1A6; dir = 1'b0; shift = 32'd12; en = 1'b1;
        step();
        en = 1'b0; in_v = 32'hFFFFFFFF; shift = 32'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (q !== 32'h5C1A6000) begin
                n_fail++;
                $display("FAIL hold edge%0d q=%h exp=%h", i, q, 32'h5C1A6000);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] vin  [8] = '{32'h7105C1A6, 32'h7105C1A6, 32'h7105C1A6, 32'h80000000,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        vdir [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] vsh  [8] = '{32'd0, 32'd0, 32'd31, 32'd31,
                                  32'd32, 32'd32, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vexp [8] = '{32'h7105C1A6, 32'h7105C1A6, 32'h0, 32'h1,
                                  32'h0, 32'h0, 32'h0, 32'h0};
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_v = vin[i]; dir = vdir[i]; shift = vsh[i];
            step();
            n_tests++;
            if (q !== vexp[i]) begin
                n_fail++;
                $display("FAIL boundary%0d dir=%0d sh=%h q=%h exp=%h",
                         i, vdir[i], vsh[i], q, vexp[i]);
            end
        end
        // Negative integer onto the unsigned amount
        in_v = 32'hA5A5A5A5; dir = 1'b0; shift = -32'sd4;
        step();
        n_tests++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL boundary_neg q=%h exp=%h", q, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin  [4] = '{32'h0000FFFF, 32'h12345678, 32'hF0000000, 32'h00000001};
        logic        vdir [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] vsh  [4] = '{32'd16, 32'd8, 32'd28, 32'd31};
        logic [31:0] vexp [4] = '{32'hFFFF0000, 32'h00123456, 32'h0000000F, 32'h80000000};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_v = vin[i]; dir = vdir[i]; shift = vsh[i];
            step();
            n_tests++;
            if (q !== vexp[i]) begin
                n_fail++;
                $display("FAIL b2b%0d q=%h exp=%h", i, q, vexp[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_v;
        logic [31:0] r;
        en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s <= 40; s++) begin
                r = $urandom();
                in_v = r; dir = d[0]; shift = s;
                if (s >= 32)      exp_v = 32'h0;
                else if (d == 1)  exp_v = r >> s;
                else              exp_v = r << s;
                step();
                n_tests++;
                if (q !== exp_v) begin
                    n_fail++;
                    $display("FAIL sweep dir=%0d sh=%0d in=%h q=%h exp=%h", d, s, r, q, exp_v);
                end
            end
        end
    endtask

    initial begin
        clr = 1'b1; en = 1'b1; dir = 1'b0; in_v = 32'h0; shift = 32'd0;
        test_reset();
        test_left();
        test_right();
        test_hold();
        test_boundaries();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
